// File: rtl/sparse_dense_mult_acc.sv
// sparse_dense_mult_acc
// Unreduced GF(2) product r(x) = sum_i x^p_i * h(x) of a sparse operand
// (list of bit positions p_i read from an external location RAM) and a dense
// operand h (read from an external word RAM). Accumulates into an internal
// 2N-bit result RAM, either after clearing it or on top of its contents.
//
// Ports
//   clk, rst_n          clock, asynchronous active-low reset
//   start, accumulate,  run request (pulse, accepted only in IDLE); mode and
//   weight              location count sampled with start
//   loc_addr / loc_in   location RAM address / data (1-cycle read latency)
//   h_addr / h_in       dense RAM address / data (1-cycle read latency)
//   busy, done          run in progress / one-cycle completion pulse
//   loc_err             sticky: some location was >= N; cleared by next start
//   res_addr / res_dout result RAM read port (1-cycle latency, idle only)
//
// state    | meaning
// IDLE     | waiting for start; result RAM read port owned by res_addr
// CLEAR    | zero result words 0..RES_DEPTH-1, one per cycle
// LOAD_LOC | present loc_addr = current location index
// WAIT_LOC | capture p = loc_in, or flag and skip an out-of-range location
// STREAM   | issue dense reads k = 0..NWORDS (last one is a zero dummy)
// DRAIN    | retire the last read-modify-write of this location
// DONE     | one-cycle done pulse
module sparse_dense_mult_acc #(
    parameter int N          = 17669,
    parameter int RAMWIDTH   = 64,
    parameter int MAX_WEIGHT = 75,
    parameter int M          = 15,
    localparam int NWORDS    = (N + RAMWIDTH - 1) / RAMWIDTH,
    localparam int RES_DEPTH = 2 * NWORDS,
    localparam int LOG_W     = $clog2(MAX_WEIGHT + 1),
    localparam int ADDR_D    = $clog2(NWORDS),
    localparam int ADDR_R    = $clog2(RES_DEPTH)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic                accumulate,
    input  logic [LOG_W-1:0]    weight,
    output logic [LOG_W-1:0]    loc_addr,
    input  logic [M-1:0]        loc_in,
    output logic [ADDR_D-1:0]   h_addr,
    input  logic [RAMWIDTH-1:0] h_in,
    output logic                busy,
    output logic                done,
    output logic                loc_err,
    input  logic [ADDR_R-1:0]   res_addr,
    output logic [RAMWIDTH-1:0] res_dout
);

    localparam int LG_RW = $clog2(RAMWIDTH);
    localparam int REM   = N % RAMWIDTH;
    localparam logic [RAMWIDTH-1:0] LAST_MASK =
        (REM == 0) ? {RAMWIDTH{1'b1}} : ~({RAMWIDTH{1'b1}} << REM);

    typedef enum logic [2:0] {
        IDLE, CLEAR, LOAD_LOC, WAIT_LOC, STREAM, DRAIN, DONE
    } state_t;

    state_t               state_q, state_d;
    logic [LOG_W-1:0]     weight_q, weight_d;
    logic [LOG_W-1:0]     idx_q, idx_d;
    logic [ADDR_R-1:0]    cnt_q, cnt_d;
    logic [M-1:0]         p_q, p_d;
    logic [RAMWIDTH-1:0]  carry_q, carry_d;
    logic                 pend_q, pend_d;
    logic                 dummy_q, dummy_d;
    logic                 lastw_q, lastw_d;
    logic [ADDR_R-1:0]    wa_q, wa_d;
    logic                 loc_err_q, loc_err_d;
    logic [RAMWIDTH-1:0]  rd_data_q, rd_data_d;

    logic [RAMWIDTH-1:0]   res_mem [RES_DEPTH];
    logic                  we_c;
    logic [ADDR_R-1:0]     wa_c;
    logic [RAMWIDTH-1:0]   wd_c;
    logic [ADDR_R-1:0]     rd_addr_c;
    logic [ADDR_R-1:0]     q_c;
    logic [LG_RW-1:0]      s_c;
    logic [RAMWIDTH-1:0]   h_eff_c;
    logic [2*RAMWIDTH-1:0] wide_c;
    logic                  last_loc_c;

    assign q_c        = ADDR_R'(p_q >> LG_RW);
    assign s_c        = p_q[LG_RW-1:0];
    assign last_loc_c = (idx_q == weight_q - LOG_W'(1));

    always_comb begin
        state_d   = state_q;
        weight_d  = weight_q;
        idx_d     = idx_q;
        cnt_d     = cnt_q;
        p_d       = p_q;
        carry_d   = carry_q;
        pend_d    = 1'b0;
        dummy_d   = 1'b0;
        lastw_d   = 1'b0;
        wa_d      = wa_q;
        loc_err_d = loc_err_q;
        we_c      = 1'b0;
        wa_c      = wa_q;
        wd_c      = '0;
        rd_addr_c = res_addr;

        // Retire stage: dense word and old result word arrive together one
        // cycle after their reads were issued; shift, merge carry, XOR back.
        h_eff_c = dummy_q ? '0 : (lastw_q ? (h_in & LAST_MASK) : h_in);
        wide_c  = {{RAMWIDTH{1'b0}}, h_eff_c} << s_c;
        if (pend_q) begin
            we_c    = 1'b1;
            wd_c    = rd_data_q ^ (wide_c[RAMWIDTH-1:0] | carry_q);
            carry_d = wide_c[2*RAMWIDTH-1:RAMWIDTH];
        end

        case (state_q)
            IDLE: begin
                if (start) begin
                    weight_d  = weight;
                    idx_d     = '0;
                    cnt_d     = '0;
                    loc_err_d = 1'b0;
                    if (!accumulate)      state_d = CLEAR;
                    else if (weight == '0) state_d = DONE;
                    else                  state_d = LOAD_LOC;
                end
            end
            CLEAR: begin
                we_c  = 1'b1;
                wa_c  = cnt_q;
                wd_c  = '0;
                cnt_d = cnt_q + ADDR_R'(1);
                if (cnt_q == ADDR_R'(RES_DEPTH - 1)) begin
                    cnt_d   = '0;
                    state_d = (weight_q == '0) ? DONE : LOAD_LOC;
                end
            end
            LOAD_LOC: state_d = WAIT_LOC;
            WAIT_LOC: begin
                if ({1'b0, loc_in} >= (M + 1)'(N)) begin
                    loc_err_d = 1'b1;
                    idx_d     = idx_q + LOG_W'(1);
                    state_d   = last_loc_c ? DONE : LOAD_LOC;
                end else begin
                    p_d     = loc_in;
                    cnt_d   = '0;
                    carry_d = '0;
                    state_d = STREAM;
                end
            end
            STREAM: begin
                rd_addr_c = q_c + cnt_q;
                wa_d      = q_c + cnt_q;
                pend_d    = 1'b1;
                dummy_d   = (cnt_q == ADDR_R'(NWORDS));
                lastw_d   = (cnt_q == ADDR_R'(NWORDS - 1));
                cnt_d     = cnt_q + ADDR_R'(1);
                if (cnt_q == ADDR_R'(NWORDS)) begin
                    cnt_d   = '0;
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                // Final write lands here; the next location's first result
                // read is at least two cycles away (LOAD_LOC, WAIT_LOC).
                idx_d   = idx_q + LOG_W'(1);
                state_d = last_loc_c ? DONE : LOAD_LOC;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        rd_data_d = res_mem[rd_addr_c];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            weight_q  <= '0;
            idx_q     <= '0;
            cnt_q     <= '0;
            p_q       <= '0;
            carry_q   <= '0;
            pend_q    <= 1'b0;
            dummy_q   <= 1'b0;
            lastw_q   <= 1'b0;
            wa_q      <= '0;
            loc_err_q <= 1'b0;
            rd_data_q <= '0;
        end else begin
            state_q   <= state_d;
            weight_q  <= weight_d;
            idx_q     <= idx_d;
            cnt_q     <= cnt_d;
            p_q       <= p_d;
            carry_q   <= carry_d;
            pend_q    <= pend_d;
            dummy_q   <= dummy_d;
            lastw_q   <= lastw_d;
            wa_q      <= wa_d;
            loc_err_q <= loc_err_d;
            rd_data_q <= rd_data_d;
        end
    end

    // Result storage is deliberately not reset; a clear-mode run defines it.
    always_ff @(posedge clk) begin
        if (we_c) res_mem[wa_c] <= wd_c;
    end

    assign busy     = (state_q != IDLE);
    assign done     = (state_q == DONE);
    assign loc_err  = loc_err_q;
    assign loc_addr = idx_q;
    assign h_addr   = (state_q == STREAM) ? cnt_q[ADDR_D-1:0] : '0;
    assign res_dout = rd_data_q;

endmodule

// File: tb/tb_sparse_dense_mult_acc.sv
// Bench for sparse_dense_mult_acc: a small instance (N=100, 16-bit words) for
// directed scenarios and a default-parameter instance for a full-size run.
module tb_sparse_dense_mult_acc;

    localparam int NS      = 100;
    localparam int NB      = 17669;
    localparam int BIGBITS = 2 * 277 * 64;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    // small instance
    logic        start_s, acc_s, busy_s, done_s, loc_err_s;
    logic [6:0]  weight_s, loc_addr_s, loc_in_s;
    logic [2:0]  h_addr_s;
    logic [15:0] h_in_s, res_dout_s;
    logic [3:0]  res_addr_s;

    // default-parameter instance
    logic        start_b, acc_b, busy_b, done_b, loc_err_b;
    logic [6:0]  weight_b, loc_addr_b;
    logic [14:0] loc_in_b;
    logic [8:0]  h_addr_b;
    logic [63:0] h_in_b, res_dout_b;
    logic [9:0]  res_addr_b;

    logic [15:0] hmem_s [0:7];
    logic [6:0]  lmem_s [0:127];
    logic [63:0] hmem_b [0:511];
    logic [14:0] lmem_b [0:127];

    always @(posedge clk) begin
        h_in_s   <= hmem_s[h_addr_s];
        loc_in_s <= lmem_s[loc_addr_s];
        h_in_b   <= hmem_b[h_addr_b];
        loc_in_b <= lmem_b[loc_addr_b];
    end

    sparse_dense_mult_acc #(.N(NS), .RAMWIDTH(16), .MAX_WEIGHT(75), .M(7)) u_small (
        .clk(clk), .rst_n(rst_n), .start(start_s), .accumulate(acc_s),
        .weight(weight_s), .loc_addr(loc_addr_s), .loc_in(loc_in_s),
        .h_addr(h_addr_s), .h_in(h_in_s), .busy(busy_s), .done(done_s),
        .loc_err(loc_err_s), .res_addr(res_addr_s), .res_dout(res_dout_s)
    );

    sparse_dense_mult_acc u_big (
        .clk(clk), .rst_n(rst_n), .start(start_b), .accumulate(acc_b),
        .weight(weight_b), .loc_addr(loc_addr_b), .loc_in(loc_in_b),
        .h_addr(h_addr_b), .h_in(h_in_b), .busy(busy_b), .done(done_b),
        .loc_err(loc_err_b), .res_addr(res_addr_b), .res_dout(res_dout_b)
    );

    int          n_vec = 0;
    int          n_mis = 0;
    logic [63:0] exp_q [$];
    bit          acc_m [0:1][0:BIGBITS-1];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Bit-level reference: XOR h shifted by each in-range location into the
    // running accumulator, then queue every result word.
    task automatic model(input bit big, input bit acc, input int w,
                         output int exp_cyc, output bit exp_err);
        int n, rw, nw, depth, bi, p;
        bit hb;
        logic [63:0] v;
        bi = big ? 1 : 0;
        n  = big ? NB : NS;
        rw = big ? 64 : 16;
        nw = (n + rw - 1) / rw;
        depth = 2 * nw;
        if (!acc) for (int i = 0; i < depth * rw; i++) acc_m[bi][i] = 1'b0;
        exp_cyc = (acc ? 0 : depth) + 1;
        exp_err = 1'b0;
        for (int i = 0; i < w; i++) begin
            p = big ? int'(lmem_b[i]) : int'(lmem_s[i]);
            if (p >= n) begin
                exp_err = 1'b1;
                exp_cyc += 2;
            end else begin
                exp_cyc += nw + 4;
                for (int j = 0; j < n; j++) begin
                    hb = big ? hmem_b[j / 64][j % 64] : hmem_s[j / 16][j % 16];
                    if (hb) acc_m[bi][p + j] ^= 1'b1;
                end
            end
        end
        for (int a = 0; a < depth; a++) begin
            v = '0;
            for (int b = 0; b < rw; b++) v[b] = acc_m[bi][a * rw + b];
            exp_q.push_back(v);
        end
    endtask

    task automatic run(input bit big, input bit acc, input int w, input bit poke,
                       output int cycles);
        @(negedge clk);
        if (big) begin start_b = 1'b1; acc_b = acc; weight_b = 7'(w); end
        else     begin start_s = 1'b1; acc_s = acc; weight_s = 7'(w); end
        @(negedge clk);
        start_b = 1'b0;
        start_s = 1'b0;
        cycles  = 1;
        while ((big ? done_b : done_s) !== 1'b1 && cycles < 25000) begin
            @(negedge clk);
            cycles++;
            start_s = poke && (cycles == 5);
        end
        start_s = 1'b0;
        @(negedge clk);
        check("done_one_cycle", big ? done_b : done_s, 1'b0);
        check("busy_after_done", big ? busy_b : busy_s, 1'b0);
    endtask

    task automatic readback(input bit big, input string name);
        int depth;
        logic [63:0] exp;
        depth = big ? 554 : 14;
        for (int a = 0; a < depth; a++) begin
            @(negedge clk);
            if (big) res_addr_b = 10'(a); else res_addr_s = 4'(a);
            @(negedge clk);
            exp = exp_q.pop_front();
            check($sformatf("%s res[%0d]", name, a), big ? res_dout_b : {48'h0, res_dout_s}, exp);
        end
    endtask

    task automatic scenario(input bit acc, input int w, input bit poke, input string name);
        int cyc, exp_cyc;
        bit exp_err;
        model(1'b0, acc, w, exp_cyc, exp_err);
        run(1'b0, acc, w, poke, cyc);
        check({name, " cycles"}, cyc, exp_cyc);
        check({name, " loc_err"}, loc_err_s, exp_err);
        readback(1'b0, name);
    endtask

    initial begin
        int cyc, exp_cyc;
        bit exp_err;

        rst_n = 1'b0;
        start_s = 0; acc_s = 0; weight_s = '0; res_addr_s = '0;
        start_b = 0; acc_b = 0; weight_b = '0; res_addr_b = '0;
        for (int i = 0; i < 8; i++)   hmem_s[i] = '0;
        for (int i = 0; i < 128; i++) begin lmem_s[i] = '0; lmem_b[i] = '0; end
        for (int i = 0; i < 512; i++) hmem_b[i] = '0;
        repeat (3) @(negedge clk);
        check("rst busy", busy_s, 1'b0);
        check("rst done", done_s, 1'b0);
        check("rst loc_err", loc_err_s, 1'b0);
        check("rst loc_addr", loc_addr_s, 7'd0);
        check("rst h_addr", h_addr_s, 3'd0);
        check("rst res_dout", res_dout_s, 16'd0);
        check("rst big busy", busy_b, 1'b0);
        rst_n = 1'b1;

        // single location at 0; garbage behind the dummy read address
        hmem_s[0] = 16'h0001; hmem_s[7] = 16'hFFFF;
        lmem_s[0] = 7'd0;
        scenario(1'b0, 1, 1'b0, "loc0");

        // word-crossing shift; a stray start mid-run must be ignored
        hmem_s[0] = 16'h8001;
        lmem_s[0] = 7'd17;
        scenario(1'b0, 1, 1'b1, "loc17");

        // duplicate locations cancel
        for (int i = 0; i < 7; i++) hmem_s[i] = 16'($urandom);
        lmem_s[0] = 7'd5; lmem_s[1] = 7'd5;
        scenario(1'b0, 2, 1'b0, "dup");

        // same product twice: clear run then accumulate run cancels
        lmem_s[0] = 7'd5; lmem_s[1] = 7'd9;
        scenario(1'b0, 2, 1'b0, "pair_clear");
        scenario(1'b1, 2, 1'b0, "pair_acc");

        // out-of-range location: flagged, skipped, sticky while idle
        lmem_s[0] = 7'd100;
        scenario(1'b0, 1, 1'b0, "oob");
        check("oob loc_err sticky", loc_err_s, 1'b1);

        // top-word mask; the next start also clears loc_err
        for (int i = 0; i < 6; i++) hmem_s[i] = '0;
        hmem_s[6] = 16'hFFFF;
        lmem_s[0] = 7'd0;
        scenario(1'b0, 1, 1'b0, "mask");

        // weight 0 in accumulate mode: straight to DONE, contents kept
        scenario(1'b1, 0, 1'b0, "w0_acc");

        // abort mid-STREAM with reset, then a fresh run
        for (int i = 0; i < 7; i++) hmem_s[i] = 16'($urandom);
        lmem_s[0] = 7'd3;
        @(negedge clk);
        start_s = 1'b1; acc_s = 1'b0; weight_s = 7'd1;
        @(negedge clk);
        start_s = 1'b0;
        repeat (18) @(negedge clk);
        check("pre_abort busy", busy_s, 1'b1);
        rst_n = 1'b0;
        #1;
        check("abort busy", busy_s, 1'b0);
        check("abort done", done_s, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        lmem_s[0] = 7'd3; lmem_s[1] = 7'd50; lmem_s[2] = 7'd99;
        scenario(1'b0, 3, 1'b0, "after_abort");

        // full-size run with default parameters
        for (int i = 0; i < 278; i++) hmem_b[i] = {$urandom, $urandom};
        for (int i = 0; i < 66; i++) lmem_b[i] = 15'($urandom_range(NB - 1));
        model(1'b1, 1'b0, 66, exp_cyc, exp_err);
        run(1'b1, 1'b0, 66, 1'b0, cyc);
        check("big cycles", cyc, exp_cyc);
        check("big cycles abs", cyc, 19101);
        check("big loc_err", loc_err_b, exp_err);
        readback(1'b1, "big");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end

endmodule
